branch_unit: RTL and testbench
==============================

BRANCH_UNIT -- requirements
Module: branch_unit

Interface
REQ-001 Parameter ADDR_W, default 16, width of branch target and program-counter load bus.
REQ-002 clk  input  1  system clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 br_req  input  1  controller request to evaluate a branch; sampled only in IDLE.
REQ-005 br_op  input  3  branch opcode, valid with br_req.
REQ-006 br_target  input  ADDR_W  branch destination, valid with br_req.
REQ-007 flag_q  input  2  registered flags from the flag register: bit0 = Z (zero), bit1 = C (carry).
REQ-008 flag_write  input  1  flag register write strobe this cycle; used for forwarding.
REQ-009 flag_wdata  input  2  flag value being written this cycle; same bit layout as flag_q.
REQ-010 pc_ack  input  1  program counter accepted the load.
REQ-011 pc_load  output  1  request to load pc_target into the PC; held until pc_ack.
REQ-012 pc_target  output  ADDR_W  latched branch destination.
REQ-013 br_busy  output  1  high in any state other than IDLE.
REQ-014 br_done  output  1  one-cycle completion pulse.
REQ-015 br_taken  output  1  result of the last completed branch; valid from br_done until the next br_done.
REQ-016 br_illegal  output  1  one-cycle pulse, coincident with br_done, for an undefined opcode.

Function
REQ-017 Opcodes: 000 JMP (always), 001 JZ (Z=1), 010 JNZ (Z=0), 011 JC (C=1), 100 JNC (C=0); 101-111 are illegal and the branch is not taken.
REQ-018 FSM states: IDLE, EVAL, LOAD, DONE; encoding is defined in the package.
REQ-019 IDLE: on br_req=1, latch br_op and br_target, then go to EVAL; otherwise stay in IDLE.
REQ-020 EVAL: evaluate the condition; go to LOAD if taken, otherwise go to DONE.
REQ-021 Flag source in EVAL: use flag_wdata when flag_write=1 in the same cycle, otherwise flag_q.
REQ-022 LOAD: pc_load=1 and pc_target is stable; go to DONE on the cycle pc_ack=1; otherwise stay in LOAD with no timeout.
REQ-023 DONE: br_done=1 for exactly one cycle, update br_taken, then go to IDLE.
REQ-024 Latency from br_req accepted at cycle T: not-taken gives br_done at T+2; taken with pc_ack in the first LOAD cycle gives pc_load at T+2 and br_done at T+3.
REQ-025 br_req while br_busy=1 is ignored and not queued; a new request is accepted only in IDLE.
REQ-026 pc_ack outside LOAD is ignored.
REQ-027 pc_load is never asserted for a not-taken or illegal branch.
REQ-028 A pc_target change is visible only after a br_req is accepted; it holds its value otherwise.

Reset
REQ-029 Reset values: state IDLE; pc_load, br_busy, br_done, br_taken, br_illegal all 0; pc_target 0.
REQ-030 rst asserted in any state, including LOAD with pc_ack pending, returns the FSM to IDLE on the next edge with no br_done pulse.

Configuration
REQ-031 Macro BRANCH_STATS_EN: when defined, the block adds outputs br_eval_cnt[15:0] and br_taken_cnt[15:0].
REQ-032 br_eval_cnt increments on each br_done; br_taken_cnt increments on each br_done with taken=1.
REQ-033 Both counters saturate at 0xFFFF and are cleared by rst.
REQ-034 Without BRANCH_STATS_EN, neither the ports nor the counter logic exist, and the behaviour of REQ-017..030 is unchanged.

Structure
REQ-035 Shared package sap_pkg holds:
- branch opcode constants;
- flag bit indices FLAG_Z=0 and FLAG_C=1;
- the branch FSM state typedef.
REQ-036 Combinational sub-module cond_eval (op, flags -> taken, illegal) holds the condition logic; the top-level holds the FSM, latches and counters.

Verification
REQ-037 Scenario 1, JZ with Z=1: flag_q=01, br_op=001, br_target=0x1234, pc_ack returned immediately -> pc_load=1 with pc_target=0x1234 at T+2; br_done=1, br_taken=1 at T+3.
REQ-038 Scenario 2, JC not taken: flag_q=00, br_op=011 -> no pc_load; br_done at T+2 with br_taken=0.
REQ-039 Scenario 3, flag forwarding: flag_q=00, then flag_write=1 with flag_wdata=01 in the EVAL cycle, br_op=001 -> taken, pc_load asserted.
REQ-040 Scenario 4, illegal opcode and busy request: br_op=110 -> br_done with br_illegal=1, br_taken=0, no pc_load; a second br_req while busy is ignored.
REQ-041 Scenario 5, pc_ack stall and reset in LOAD:
- JMP with pc_ack held low 5 cycles: pc_load held 5 cycles with pc_target stable, then br_done.
- rst asserted in LOAD: IDLE and pc_load=0 on the next edge, no br_done.
REQ-042 Scenario 6, statistics (BRANCH_STATS_EN defined): 3 taken and 2 not-taken branches -> br_eval_cnt=5, br_taken_cnt=3.

Source files
------------

// File: rtl/sap_pkg.sv
// -----------------------------------------------------------------------------
// sap_pkg -- definitions shared by the branch unit and its condition evaluator.
//   * Branch opcode constants (JMP, JZ, JNZ, JC, JNC; 101..111 are undefined)
//   * Flag bit positions inside the 2-bit flag word {C, Z}
//   * Branch FSM state type
// -----------------------------------------------------------------------------
package sap_pkg;

    localparam logic [2:0] OP_JMP = 3'b000;
    localparam logic [2:0] OP_JZ  = 3'b001;
    localparam logic [2:0] OP_JNZ = 3'b010;
    localparam logic [2:0] OP_JC  = 3'b011;
    localparam logic [2:0] OP_JNC = 3'b100;

    localparam int FLAG_Z = 0;
    localparam int FLAG_C = 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EVAL = 2'd1,
        ST_LOAD = 2'd2,
        ST_DONE = 2'd3
    } br_state_t;

endpackage

// File: rtl/cond_eval.sv
// -----------------------------------------------------------------------------
// cond_eval -- purely combinational branch condition decoder.
// Ports:
//   op      [2:0] in   branch opcode
//   flags   [1:0] in   flag word, bit FLAG_Z = zero, bit FLAG_C = carry
//   taken         out  branch condition satisfied
//   illegal       out  opcode undefined (never reported as taken)
// -----------------------------------------------------------------------------
module cond_eval
    import sap_pkg::*;
(
    input  logic [2:0] op,
    input  logic [1:0] flags,
    output logic       taken,
    output logic       illegal
);

    always_comb begin
        taken   = 1'b0;
        illegal = 1'b0;
        case (op)
            OP_JMP:  taken = 1'b1;
            OP_JZ:   taken = flags[FLAG_Z];
            OP_JNZ:  taken = ~flags[FLAG_Z];
            OP_JC:   taken = flags[FLAG_C];
            OP_JNC:  taken = ~flags[FLAG_C];
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/branch_unit.sv
// -----------------------------------------------------------------------------
// branch_unit -- evaluates a conditional branch and hands the target to the PC.
//
// Sequence: IDLE accepts br_req and latches op/target, EVAL resolves the
// condition (forwarding a flag write of the same cycle), LOAD holds pc_load
// until pc_ack, DONE pulses br_done and publishes br_taken.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   br_req, br_op, br_target branch request, opcode and destination
//   flag_q                   registered flags {C, Z}
//   flag_write, flag_wdata   flag register write this cycle (forwarded in EVAL)
//   pc_ack                   PC accepted the load (only meaningful in LOAD)
//   pc_load, pc_target       PC load request and latched destination
//   br_busy                  unit not in IDLE
//   br_done, br_illegal      one-cycle completion / undefined-opcode pulses
//   br_taken                 result of the last completed branch
//
// Optional (macro BRANCH_STATS_EN): br_eval_cnt, br_taken_cnt -- saturating
// 16-bit counts of completed and of taken branches.
// -----------------------------------------------------------------------------
module branch_unit
    import sap_pkg::*;
#(
    parameter int ADDR_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              br_req,
    input  logic [2:0]        br_op,
    input  logic [ADDR_W-1:0] br_target,
    input  logic [1:0]        flag_q,
    input  logic              flag_write,
    input  logic [1:0]        flag_wdata,
    input  logic              pc_ack,
    output logic              pc_load,
    output logic [ADDR_W-1:0] pc_target,
    output logic              br_busy,
    output logic              br_done,
    output logic              br_taken,
    output logic              br_illegal
`ifdef BRANCH_STATS_EN
    ,
    output logic [15:0]       br_eval_cnt,
    output logic [15:0]       br_taken_cnt
`endif
);

    br_state_t         state_reg;
    logic [2:0]        op_reg;
    logic [ADDR_W-1:0] target_reg;
    logic              pc_load_reg;
    logic              busy_reg;
    logic              done_reg;
    logic              taken_reg;
    logic              illegal_reg;

    logic [1:0]        eval_flags;
    logic              cond_taken;
    logic              cond_illegal;

    // A flag write landing in the EVAL cycle is not yet visible in flag_q.
    assign eval_flags = flag_write ? flag_wdata : flag_q;

    cond_eval u_cond_eval (
        .op      (op_reg),
        .flags   (eval_flags),
        .taken   (cond_taken),
        .illegal (cond_illegal)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= ST_IDLE;
            op_reg      <= 3'b000;
            target_reg  <= '0;
            pc_load_reg <= 1'b0;
            busy_reg    <= 1'b0;
            done_reg    <= 1'b0;
            taken_reg   <= 1'b0;
            illegal_reg <= 1'b0;
        end else begin
            done_reg    <= 1'b0;
            illegal_reg <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (br_req) begin
                        op_reg     <= br_op;
                        target_reg <= br_target;
                        busy_reg   <= 1'b1;
                        state_reg  <= ST_EVAL;
                    end
                end
                ST_EVAL: begin
                    if (cond_taken) begin
                        pc_load_reg <= 1'b1;
                        state_reg   <= ST_LOAD;
                    end else begin
                        // Not-taken and illegal branches skip LOAD entirely.
                        done_reg    <= 1'b1;
                        taken_reg   <= 1'b0;
                        illegal_reg <= cond_illegal;
                        state_reg   <= ST_DONE;
                    end
                end
                ST_LOAD: begin
                    if (pc_ack) begin
                        pc_load_reg <= 1'b0;
                        done_reg    <= 1'b1;
                        taken_reg   <= 1'b1;
                        state_reg   <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    busy_reg  <= 1'b0;
                    state_reg <= ST_IDLE;
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    assign pc_load    = pc_load_reg;
    assign pc_target  = target_reg;
    assign br_busy    = busy_reg;
    assign br_done    = done_reg;
    assign br_taken   = taken_reg;
    assign br_illegal = illegal_reg;

`ifdef BRANCH_STATS_EN
    logic [15:0] eval_cnt_reg;
    logic [15:0] taken_cnt_reg;

    // Counters follow the br_done pulse, so they update one cycle after it.
    always_ff @(posedge clk) begin
        if (rst) begin
            eval_cnt_reg  <= 16'h0000;
            taken_cnt_reg <= 16'h0000;
        end else if (done_reg) begin
            if (eval_cnt_reg != 16'hFFFF)
                eval_cnt_reg <= eval_cnt_reg + 16'd1;
            if (taken_reg && (taken_cnt_reg != 16'hFFFF))
                taken_cnt_reg <= taken_cnt_reg + 16'd1;
        end
    end

    assign br_eval_cnt  = eval_cnt_reg;
    assign br_taken_cnt = taken_cnt_reg;
`endif

endmodule

// File: tb/tb_branch_unit.sv
// -----------------------------------------------------------------------------
// tb_branch_unit -- self-checking bench for branch_unit (directed scenarios
// followed by randomized branches checked against a behavioural model).
// Define BRANCH_STATS_EN to also check the statistics counters.
// -----------------------------------------------------------------------------
module tb_branch_unit;

    localparam int ADDR_W = 16;

    logic              clk = 1'b0;
    logic              rst;
    logic              br_req;
    logic [2:0]        br_op;
    logic [ADDR_W-1:0] br_target;
    logic [1:0]        flag_q;
    logic              flag_write;
    logic [1:0]        flag_wdata;
    logic              pc_ack;
    logic              pc_load;
    logic [ADDR_W-1:0] pc_target;
    logic              br_busy;
    logic              br_done;
    logic              br_taken;
    logic              br_illegal;
`ifdef BRANCH_STATS_EN
    logic [15:0]       br_eval_cnt;
    logic [15:0]       br_taken_cnt;
`endif

    branch_unit #(.ADDR_W(ADDR_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .br_req     (br_req),
        .br_op      (br_op),
        .br_target  (br_target),
        .flag_q     (flag_q),
        .flag_write (flag_write),
        .flag_wdata (flag_wdata),
        .pc_ack     (pc_ack),
        .pc_load    (pc_load),
        .pc_target  (pc_target),
        .br_busy    (br_busy),
        .br_done    (br_done),
        .br_taken   (br_taken),
        .br_illegal (br_illegal)
`ifdef BRANCH_STATS_EN
        ,
        .br_eval_cnt  (br_eval_cnt),
        .br_taken_cnt (br_taken_cnt)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference state: number of completed / taken branches since reset and
    // the last published branch outcome.
    int model_evals = 0;
    int model_takens = 0;
    bit model_last_taken = 1'b0;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Branch semantics from the opcode table; flags = {C, Z}.
    function automatic bit ref_taken(input logic [2:0] op, input logic [1:0] flags);
        bit z = flags[0];
        bit c = flags[1];
        case (op)
            3'd0:    return 1'b1;
            3'd1:    return z;
            3'd2:    return !z;
            3'd3:    return c;
            3'd4:    return !c;
            default: return 1'b0;
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_stats(input string tag);
`ifdef BRANCH_STATS_EN
        check({tag, "_eval_cnt"},  {16'h0, br_eval_cnt},
              (model_evals  > 65535) ? 32'hFFFF : 32'(model_evals));
        check({tag, "_taken_cnt"}, {16'h0, br_taken_cnt},
              (model_takens > 65535) ? 32'hFFFF : 32'(model_takens));
`else
        if (tag.len() == 0) $display("empty stats tag");
`endif
    endtask

    // Runs one complete branch. Entered just after an edge with the DUT idle;
    // returns just after the edge that brings it back to IDLE.
    task automatic run_branch(input string name, input logic [2:0] op, input logic [15:0] tgt,
                              input logic [1:0] fq, input bit fwd_en, input logic [1:0] fwd,
                              input int ack_delay, input bit busy_req);
        bit exp_taken = ref_taken(op, fwd_en ? fwd : fq);
        bit exp_ill = (op > 3'd4);
        int load_cycles = 0;

        // Cycle T: present the request.
        flag_q = fq; br_op = op; br_target = tgt; br_req = 1'b1;
        flag_write = 1'b0; pc_ack = 1'b0;
        tick();
        // Cycle T+1 (EVAL): disturb inputs that must be ignored.
        br_req = busy_req; br_op = 3'($urandom); br_target = 16'($urandom);
        flag_write = fwd_en; flag_wdata = fwd;
        pc_ack = 1'($urandom);
        check({name, "_eval_busy"}, 32'(br_busy), 32'd1);
        check({name, "_eval_pcload"}, 32'(pc_load), 32'd0);
        check({name, "_eval_done"}, 32'(br_done), 32'd0);
        tick();
        flag_write = 1'b0; flag_wdata = 2'($urandom); pc_ack = 1'b0;
        // Cycle T+2: LOAD for taken branches, DONE otherwise.
        if (exp_taken) begin
            for (int i = 0; i <= ack_delay; i++) begin
                check({name, "_load_pcload"}, 32'(pc_load), 32'd1);
                check({name, "_load_target"}, 32'(pc_target), 32'(tgt));
                check({name, "_load_done"}, 32'(br_done), 32'd0);
                pc_ack = (i == ack_delay);
                load_cycles++;
                tick();
            end
            pc_ack = 1'b0;
        end
        br_req = 1'b0;
        pc_ack = 1'($urandom);
        model_evals++;
        if (exp_taken) model_takens++;
        model_last_taken = exp_taken;
        check({name, "_done"}, 32'(br_done), 32'd1);
        check({name, "_taken"}, 32'(br_taken), 32'(exp_taken));
        check({name, "_illegal"}, 32'(br_illegal), 32'(exp_ill));
        check({name, "_done_pcload"}, 32'(pc_load), 32'd0);
        check({name, "_load_cycles"}, 32'(load_cycles), exp_taken ? 32'(ack_delay + 1) : 32'd0);
        tick();
        pc_ack = 1'b0;
        // Back in IDLE: no queued request, outputs hold.
        check({name, "_idle_busy"}, 32'(br_busy), 32'd0);
        check({name, "_idle_done"}, 32'(br_done), 32'd0);
        check({name, "_idle_illegal"}, 32'(br_illegal), 32'd0);
        check({name, "_idle_taken_hold"}, 32'(br_taken), 32'(model_last_taken));
        check({name, "_idle_target_hold"}, 32'(pc_target), 32'(tgt));
        check_stats(name);
        $display("branch %s op=%0d tgt=%04h flags=%02b fwd=%0d/%02b ack_delay=%0d busy_req=%0d -> taken=%0d illegal=%0d",
                 name, op, tgt, fq, fwd_en, fwd, ack_delay, busy_req, exp_taken, exp_ill);
    endtask

    initial begin
        rst = 1'b1; br_req = 1'b0; br_op = 3'd0; br_target = '0;
        flag_q = 2'b00; flag_write = 1'b0; flag_wdata = 2'b00; pc_ack = 1'b0;
        tick();
        tick();
        check("rst_pcload", 32'(pc_load), 32'd0);
        check("rst_busy", 32'(br_busy), 32'd0);
        check("rst_done", 32'(br_done), 32'd0);
        check("rst_taken", 32'(br_taken), 32'd0);
        check("rst_illegal", 32'(br_illegal), 32'd0);
        check("rst_target", 32'(pc_target), 32'd0);
        check_stats("rst");
        rst = 1'b0;

        // Directed scenarios.
        run_branch("jz_taken",   3'b001, 16'h1234, 2'b01, 1'b0, 2'b00, 0, 1'b0);
        run_branch("jc_not",     3'b011, 16'h0BAD, 2'b00, 1'b0, 2'b00, 0, 1'b0);
        run_branch("jz_forward", 3'b001, 16'h4567, 2'b00, 1'b1, 2'b01, 0, 1'b0);
        run_branch("jnz_fwdoff", 3'b010, 16'h2222, 2'b01, 1'b1, 2'b00, 1, 1'b0);
        run_branch("illegal",    3'b110, 16'h7777, 2'b11, 1'b0, 2'b00, 0, 1'b1);
        run_branch("jmp_stall",  3'b000, 16'hBEEF, 2'b00, 1'b0, 2'b00, 5, 1'b1);

        // Reset while LOAD waits for pc_ack.
        flag_q = 2'b00; br_op = 3'b000; br_target = 16'hCAFE; br_req = 1'b1;
        tick();
        br_req = 1'b0;
        tick();
        check("rstload_pcload_before", 32'(pc_load), 32'd1);
        rst = 1'b1; pc_ack = 1'b1;
        tick();
        rst = 1'b0; pc_ack = 1'b0;
        model_evals = 0; model_takens = 0; model_last_taken = 1'b0;
        check("rstload_pcload", 32'(pc_load), 32'd0);
        check("rstload_busy", 32'(br_busy), 32'd0);
        check("rstload_done", 32'(br_done), 32'd0);
        check("rstload_target", 32'(pc_target), 32'd0);
        tick();
        check("rstload_no_done", 32'(br_done), 32'd0);
        check("rstload_idle", 32'(br_busy), 32'd0);
        check_stats("rstload");
        $display("reset in LOAD handled");

        // Statistics mix: three taken, two not taken.
        run_branch("st_jmp", 3'b000, 16'h0100, 2'b00, 1'b0, 2'b00, 0, 1'b0);
        run_branch("st_jnc", 3'b100, 16'h0200, 2'b00, 1'b0, 2'b00, 1, 1'b0);
        run_branch("st_jz0", 3'b001, 16'h0300, 2'b10, 1'b0, 2'b00, 0, 1'b0);
        run_branch("st_jc",  3'b011, 16'h0400, 2'b10, 1'b0, 2'b00, 2, 1'b0);
        run_branch("st_jnz", 3'b010, 16'h0500, 2'b01, 1'b0, 2'b00, 0, 1'b0);
`ifdef BRANCH_STATS_EN
        check("stats_eval_5", {16'h0, br_eval_cnt}, 32'd5);
        check("stats_taken_3", {16'h0, br_taken_cnt}, 32'd3);
`endif

        // Randomized branches.
        for (int n = 0; n < 40; n++) begin
            run_branch($sformatf("rnd%0d", n), 3'($urandom_range(0, 7)), 16'($urandom),
                       2'($urandom), 1'($urandom), 2'($urandom),
                       $urandom_range(0, 3), 1'($urandom));
            repeat ($urandom_range(0, 2)) tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Watchdog so a broken DUT cannot hang the run.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
